imem_loader: RTL
================

# imem_loader

Byte-stream program loader that writes the instruction memory through its write port. It sits between a host byte source (UART receiver or test bench) and the instruction memory, and holds the CPU while a frame is being written. It parses framed load records and streams payload bytes to consecutive addresses. When checksums are enabled, it verifies each record's checksum.

## Interface
- ADDR_W, 8: instruction-memory address width; address arithmetic wraps modulo 2^ADDR_W.
- SYNC_BYTE, 8'hA5: frame start marker.
- TIMEOUT_CYCLES, 1024: number of idle cycles inside a frame before the frame is abandoned.
- clk  in  1  system clock; all state is updated on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  host byte valid.
- in_data  in  8  host byte.
- in_ready  out  1  loader can accept a byte.
- mem_we  out  1  instruction-memory write strobe, one cycle per byte.
- mem_waddr  out  ADDR_W  write address.
- mem_wdata  out  8  write data.
- cpu_hold  out  1  stalls the CPU / PC while high.
- busy  out  1  high in any state other than IDLE.
- load_done  out  1  one-cycle pulse when a frame completes successfully.
- load_err  out  1  one-cycle pulse on checksum failure or timeout.

## Operation
- Frame format: SYNC, ADDR, LEN, LEN data bytes, CHK.
  - LEN = 0 means 256 bytes.
  - CHK = XOR of ADDR, LEN and all data bytes.
- A byte is accepted on a rising edge where in_valid && in_ready.
- FSM states: IDLE, ADDR, LEN, DATA, CHK, DONE.
- IDLE:
  - Accepting SYNC_BYTE moves to ADDR.
  - Any other byte is discarded and the state stays IDLE.
- ADDR: the accepted byte loads the address pointer and seeds the checksum; move to LEN.
- LEN: the accepted byte loads the remaining count (0 loads 256); move to DATA.
- DATA: each accepted byte:
  - issues a write at the pointer,
  - increments the pointer with wrap (8'hFF goes to 8'h00),
  - decrements the count and XORs into the checksum.
  - On the last byte, move to CHK.
- CHK:
  - If the accepted byte equals the running checksum, pulse load_done.
  - Otherwise pulse load_err and set the sticky hold_err.
  - Move to DONE.
- DONE: one cycle with in_ready = 0, then IDLE.
- Payload writes are not rolled back on error; the memory may be partially updated.
- cpu_hold behaviour:
  - Rises on SYNC acceptance.
  - Falls in the cycle after a load_done pulse.
  - After an error or timeout it stays high while hold_err = 1.
  - hold_err is cleared only by a subsequent good frame or by reset.
- Timeout:
  - In ADDR, LEN, DATA or CHK, a counter increments every cycle with no accepted byte and clears on every acceptance.
  - When it reaches TIMEOUT_CYCLES: pulse load_err, set hold_err, go to IDLE.
- A SYNC_BYTE value arriving inside a frame is treated as ordinary data; there is no resynchronisation mid-frame.
- Reset mid-frame: all state returns to its reset values immediately; no further writes are issued.

## Timing
- Reset values:
  - in_ready = 0 while rst is low; 1 from the first clock after release (except in DONE).
  - mem_we = 0, mem_waddr = 0, mem_wdata = 0.
  - cpu_hold = 0, busy = 0, load_done = 0, load_err = 0.
  - State IDLE, hold_err = 0.
- Write latency: mem_we, mem_waddr and mem_wdata are registered and valid in the cycle after the data byte is accepted. mem_we stays high for exactly one cycle per byte.
- The memory write port samples on the falling edge of that cycle, so data is visible to reads one cycle after acceptance.
- Throughput: one byte per cycle; in_ready is combinationally independent of in_valid.
- load_done / load_err are asserted in the cycle after CHK acceptance (or the timeout cycle).
- busy is high from the cycle after SYNC acceptance until the return to IDLE.

## Configuration
- IMEM_LOADER_CHK_EN defined: CHK state present, checksum verified as above.
- IMEM_LOADER_CHK_EN undefined:
  - No CHK byte is expected; LEN → DATA → DONE.
  - load_done pulses after the last data byte.
  - load_err arises only from timeout.

## Structure
- Package imem_loader_pkg holds:
  - the state enum type imem_loader_state_t,
  - the default SYNC_BYTE constant,
  - the LEN = 0 → 256 count width constant (9 bits).
- Sub-module imem_loader_timer: the resettable timeout counter, with inputs clr and en and output expired.

## Test plan
- Good frame: A5, 10, 03, 11, 22, 33, CHK = 10^03^11^22^33.
  - Writes 11/22/33 at addresses 10/11/12.
  - load_done pulses once; cpu_hold falls the next cycle.
- Wrap: A5, FE, 03, AA, BB, CC, good CHK.
  - Writes at FE, FF, 00.
  - No write outside these addresses.
- Bad CHK: good frame with CHK ^ 8'h01.
  - All data bytes are written; load_err pulses.
  - cpu_hold stays 1 until a following good frame completes.
- Timeout: A5, 20, 05, 01, then in_valid low for TIMEOUT_CYCLES.
  - load_err pulses, state returns to IDLE, cpu_hold stays 1.
- Garbage and LEN = 0: bytes 00, FF, 5A before A5, 00, 00, then 256 bytes.
  - Garbage is ignored; all 256 addresses are written.
- Async reset: assert rst low in the middle of DATA.
  - mem_we = 0 immediately.
  - All outputs take their reset values; no writes after release.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory byte-stream loader.
package imem_loader_pkg;
  typedef enum logic [2:0] {
    ST_IDLE, ST_ADDR, ST_LEN, ST_DATA, ST_CHK, ST_DONE
  } imem_loader_state_t;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  // LEN byte 0 encodes a 256-byte payload, so the remaining count needs 9 bits.
  localparam int CNT_W = 9;
endpackage

// File: rtl/imem_loader_if.sv
// Host byte stream, instruction-memory write port and loader status.
interface imem_loader_if #(parameter int ADDR_W = 8) ();
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [7:0]        mem_wdata;
  logic              cpu_hold;
  logic              busy;
  logic              load_done;
  logic              load_err;

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_waddr, mem_wdata, cpu_hold, busy, load_done, load_err
  );
  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_waddr, mem_wdata, cpu_hold, busy, load_done, load_err
  );
endinterface

// File: rtl/imem_loader_timer.sv
// Idle-cycle counter for frame abandonment; expired flags the last idle cycle.
module imem_loader_timer #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT_CYCLES + 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      r_cnt <= '0;
    else if (clr)  r_cnt <= '0;
    else if (en)   r_cnt <= r_cnt + W'(1);
  end

  // High during the cycle whose edge brings the count to TIMEOUT_CYCLES.
  assign expired = en && (r_cnt == W'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader: SYNC, ADDR, LEN, data..., [CHK] into instruction memory.
// Define IMEM_LOADER_CHK_EN to expect and verify the trailing XOR checksum byte.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int         ADDR_W         = 8,
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEF,
  parameter int         TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  imem_loader_if.slave bus
);
  imem_loader_state_t r_state, w_next;

  logic              r_rdy_en;
  logic [ADDR_W-1:0] r_ptr;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_hold, r_hold_err, r_done, r_err, r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [7:0]        r_wdata;

  logic w_ready, w_acc, w_in_frame, w_last, w_good, w_bad, w_expired, w_sync;

  assign w_ready    = r_rdy_en && (r_state != ST_DONE);
  assign w_acc      = bus.in_valid && w_ready;
  assign w_in_frame = (r_state == ST_ADDR) || (r_state == ST_LEN) ||
                      (r_state == ST_DATA) || (r_state == ST_CHK);
  assign w_sync     = (r_state == ST_IDLE) && w_acc && (bus.in_data == SYNC_BYTE);
  assign w_last     = (r_state == ST_DATA) && w_acc && (r_cnt == CNT_W'(1));

`ifdef IMEM_LOADER_CHK_EN
  logic [7:0] r_chk;
  logic       w_chk_ok;
  assign w_chk_ok = (bus.in_data == r_chk);
  assign w_good   = (r_state == ST_CHK) && w_acc && w_chk_ok;
  assign w_bad    = (r_state == ST_CHK) && w_acc && !w_chk_ok;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                      r_chk <= '0;
    else if (w_acc && r_state == ST_ADDR)          r_chk <= bus.in_data;
    else if (w_acc && (r_state == ST_LEN || r_state == ST_DATA))
                                                   r_chk <= r_chk ^ bus.in_data;
  end
`else
  assign w_good = w_last;
  assign w_bad  = 1'b0;
`endif

  imem_loader_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (w_acc || !w_in_frame),
    .en      (w_in_frame && !w_acc),
    .expired (w_expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_sync) w_next = ST_ADDR;
      ST_ADDR: if (w_acc)  w_next = ST_LEN;
      ST_LEN:  if (w_acc)  w_next = ST_DATA;
`ifdef IMEM_LOADER_CHK_EN
      ST_DATA: if (w_last) w_next = ST_CHK;
`else
      ST_DATA: if (w_last) w_next = ST_DONE;
`endif
      ST_CHK:  if (w_acc)  w_next = ST_DONE;
      ST_DONE:             w_next = ST_IDLE;
      default:             w_next = ST_IDLE;
    endcase
    if (w_expired) w_next = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdy_en   <= 1'b0;
      r_ptr      <= '0;
      r_cnt      <= '0;
      r_hold     <= 1'b0;
      r_hold_err <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_we       <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
    end else begin
      r_rdy_en <= 1'b1;
      r_we     <= 1'b0;
      r_done   <= w_good;
      r_err    <= w_bad || w_expired;
      if (w_acc) begin
        case (r_state)
          ST_ADDR: r_ptr <= ADDR_W'(bus.in_data);
          ST_LEN:  r_cnt <= (bus.in_data == 8'h00) ? CNT_W'(256) : CNT_W'(bus.in_data);
          ST_DATA: begin
            r_we    <= 1'b1;
            r_waddr <= r_ptr;
            r_wdata <= bus.in_data;
            r_ptr   <= r_ptr + ADDR_W'(1);
            r_cnt   <= r_cnt - CNT_W'(1);
          end
          default: ;
        endcase
      end
      if (w_good)                 r_hold_err <= 1'b0;
      else if (w_bad || w_expired) r_hold_err <= 1'b1;
      // Hold is released only at the end of DONE, and only if no error is pending.
      if (w_sync)                 r_hold <= 1'b1;
      else if (r_state == ST_DONE) r_hold <= r_hold_err;
    end
  end

  assign bus.in_ready  = w_ready;
  assign bus.mem_we    = r_we;
  assign bus.mem_waddr = r_waddr;
  assign bus.mem_wdata = r_wdata;
  assign bus.cpu_hold  = r_hold;
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.load_done = r_done;
  assign bus.load_err  = r_err;
endmodule
